// File: rtl/alu_arbiter_if.sv
// Bundle of the two request ports, the ALU control/result bus and the response channel.
// The slave modport is the arbiter's view; master is the client/ALU side.
interface alu_arbiter_if #(parameter int WIDTH = 16);
  logic             req0_valid, req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;

  logic [WIDTH-1:0] alu_src1, alu_src2;
  logic             alu_invert_a, alu_invert_b;
  logic [1:0]       alu_operation;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero, alu_overflow;

  logic             resp_valid, resp_ready, resp_id;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero, resp_overflow, resp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_src1, alu_src2, alu_invert_a, alu_invert_b, alu_operation,
    input  alu_result, alu_zero, alu_overflow,
    output resp_valid, resp_id, resp_result, resp_zero, resp_overflow, resp_err,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_src1, alu_src2, alu_invert_a, alu_invert_b, alu_operation,
    output alu_result, alu_zero, alu_overflow,
    input  resp_valid, resp_id, resp_result, resp_zero, resp_overflow, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters:
// grant in IDLE, drive ALU in EXEC, hold a tagged response in RESP until accepted.
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
                         OP_SLT = 3'b100, OP_NOR = 3'b101, OP_NAND = 3'b110, OP_RSV = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state, w_next;
  logic             r_last_grant, r_id;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_resp_valid, r_resp_zero, r_resp_ovf, r_resp_err;
  logic [WIDTH-1:0] r_resp_result;

  logic             w_rdy0, w_rdy1, w_grant, w_pick1;
  logic             w_inv_a, w_inv_b;
  logic [1:0]       w_oper;
  logic [WIDTH-1:0] w_src1, w_src2;
  logic             w_ovf_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    w_next  = r_state;
    w_rdy0  = 1'b0;
    w_rdy1  = 1'b0;
    w_pick1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
    w_grant = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant = bus.req0_valid | bus.req1_valid;
        w_rdy1  = w_pick1;
        w_rdy0  = bus.req0_valid & ~w_pick1;
        if (w_grant) w_next = EXEC;
      end
      EXEC:    w_next = RESP;
      RESP:    if (bus.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_inv_a  = 1'b0;
    w_inv_b  = 1'b0;
    w_oper   = 2'b00;
    w_ovf_ok = 1'b0;
    case (r_op)
      OP_AND:  w_oper = 2'b00;
      OP_OR:   w_oper = 2'b01;
      OP_ADD:  begin w_oper = 2'b10; w_ovf_ok = 1'b1; end
      OP_SUB:  begin w_inv_b = 1'b1; w_oper = 2'b10; w_ovf_ok = 1'b1; end
      OP_SLT:  begin w_inv_b = 1'b1; w_oper = 2'b11; end
      OP_NOR:  begin w_inv_a = 1'b1; w_inv_b = 1'b1; w_oper = 2'b00; end
      OP_NAND: begin w_inv_a = 1'b1; w_inv_b = 1'b1; w_oper = 2'b01; end
      default: ;
    endcase
  end

  // ALU sees live operands only in EXEC with a legal opcode; otherwise all zero.
  always_comb begin
    w_src1 = '0;
    w_src2 = '0;
    if (r_state == EXEC && r_op != OP_RSV) begin
      w_src1 = r_a;
      w_src2 = r_b;
    end
  end

  assign bus.req0_ready    = w_rdy0;
  assign bus.req1_ready    = w_rdy1;
  assign bus.alu_src1      = w_src1;
  assign bus.alu_src2      = w_src2;
  assign bus.alu_invert_a  = (r_state == EXEC) & w_inv_a;
  assign bus.alu_invert_b  = (r_state == EXEC) & w_inv_b;
  assign bus.alu_operation = (r_state == EXEC) ? w_oper : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
    end else if (w_grant) begin
      r_last_grant <= w_pick1;
      r_id         <= w_pick1;
      r_op         <= w_pick1 ? bus.req1_op : bus.req0_op;
      r_a          <= w_pick1 ? bus.req1_a  : bus.req0_a;
      r_b          <= w_pick1 ? bus.req1_b  : bus.req0_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid  <= 1'b0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
      r_resp_ovf    <= 1'b0;
      r_resp_err    <= 1'b0;
    end else if (r_state == EXEC) begin
      r_resp_valid  <= 1'b1;
      r_resp_err    <= (r_op == OP_RSV);
      r_resp_result <= (r_op == OP_RSV) ? '0 : bus.alu_result;
      r_resp_zero   <= (r_op != OP_RSV) & bus.alu_zero;
      r_resp_ovf    <= w_ovf_ok & bus.alu_overflow;
    end else if (r_state == RESP && bus.resp_ready) begin
      r_resp_valid  <= 1'b0;
    end
  end

  logic r_resp_id;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_resp_id <= 1'b0;
    else if (r_state == EXEC)   r_resp_id <= r_id;
  end

  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_id       = r_resp_id;
  assign bus.resp_result   = r_resp_result;
  assign bus.resp_zero     = r_resp_zero;
  assign bus.resp_overflow = r_resp_ovf;
  assign bus.resp_err      = r_resp_err;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing controller that shares one combinational 16-bit ALU between two requesters. It arbitrates requests round-robin and latches the winner's operands and opcode. It then decodes the opcode into the ALU's invertA/invertB/operation controls, captures result/zero/overflow, and returns them on a single response channel tagged with the requester id. It sits between the datapath clients and the ALU instance, which remains purely combinational.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must match the ALU (16).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid / req1_valid  input  1  request present on port 0 / 1
- req0_ready / req1_ready  output  1  request accepted this cycle on port 0 / 1
- req0_op / req1_op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 NAND, 111 reserved
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands
- alu_src1, alu_src2  output  WIDTH  operands driven to the ALU
- alu_invert_a, alu_invert_b  output  1  ALU invert controls
- alu_operation  output  2  ALU op: 00 AND, 01 OR, 10 add, 11 less/set
- alu_result  input  WIDTH  ALU result
- alu_zero, alu_overflow  input  1  ALU flags
- resp_valid  output  1  response held valid
- resp_ready  input  1  consumer accepts response
- resp_id  output  1  requester that issued the op
- resp_result  output  WIDTH  captured result
- resp_zero, resp_overflow, resp_err  output  1  captured flags; err = reserved opcode

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - The arbiter picks one valid requester and raises its ready for that cycle.
  - On grant it latches op, a, b and id, records last_grant, and moves to EXEC.
  - Ready outputs are combinational from the valids and the state; they are never high outside IDLE.
- Round-robin:
  - If only one requester is valid, it wins.
  - If both are valid, the port not equal to last_grant wins.
  - last_grant resets to 1, so port 0 wins the first tie.
- EXEC: the ALU is driven from the latched operands and decoded controls.
  - At the end of the cycle, result/zero/overflow are captured into the resp_* registers and the FSM moves to RESP.
- Decode (invA, invB, operation):
  - AND 0,0,00; OR 0,0,01; ADD 0,0,10; SUB 0,1,10; SLT 0,1,11; NOR 1,1,00; NAND 1,1,01.
- Overflow masking: resp_overflow = alu_overflow only for ADD/SUB; forced to 0 for all other ops.
- Reserved op 111:
  - The ALU is driven with zero operands and controls 0,0,00.
  - Capture is resp_result=0, resp_zero=0, resp_overflow=0, resp_err=1.
  - resp_err=0 for all valid ops.
- ALU outputs outside EXEC: alu_src1/alu_src2 hold 0 and controls are 0,0,00.
- RESP: resp_valid=1 and all resp_* fields are held stable until resp_ready=1.
  - When resp_ready is sampled high, the FSM returns to IDLE.
  - No new grant occurs in that same cycle; the next grant is possible in the following IDLE cycle.
- Requests are never dropped. A non-granted valid requester keeps waiting, and its inputs must stay stable until its ready.

## Timing
- Reset (asynchronous, immediate) gives:
  - state=IDLE, last_grant=1
  - resp_valid=0, resp_id=0, resp_result=0, resp_zero=0, resp_overflow=0, resp_err=0
  - alu_* outputs all 0
- Reset mid-operation, in EXEC or RESP: the in-flight op is discarded and no response is issued.
- Latency: accept at cycle T, EXEC at T+1, resp_valid high from T+2.
  - With resp_ready tied high, the minimum issue interval is 3 cycles.
- resp_valid deasserts the cycle after the handshake.
- Backpressure: while resp_valid=1 and resp_ready=0, the block stalls indefinitely with all outputs stable and both readys low.
- Simultaneous events: a new request arriving during the RESP-accept cycle is not granted until the next cycle.
- Width rule: all arithmetic is WIDTH-bit two's complement; carry-out is not reported.

## Test plan
- Port 0 only, ADD a=0x7FFF b=0x0001 -> ready0 at T, resp_valid at T+2 with id=0, result=0x8000, overflow=1, zero=0, err=0.
- Port 1 only, SUB a=0x0005 b=0x0005 -> result=0x0000, zero=1, overflow=0; then SLT a=0x0003 b=0x0005 -> result=0x0001, overflow=0.
- Both valid continuously, port 0 AND 0xF0F0&0x0FF0 and port 1 OR 0xF0F0|0x0F0F -> grant order 0,1,0,1; results 0x00F0 / 0xFFFF with matching resp_id.
- Reserved op 111 with a=0x1234 -> alu_src1=0 during EXEC; response result=0, err=1, zero=0.
- resp_ready held low 5 cycles after a NOR 0x0000,0x0000 (result 0xFFFF) -> response stable, both readys low, req1 waiting; it is granted the cycle after the handshake.
- Assert rst during EXEC of ADD 0x0001+0x0001 -> no response; all outputs 0; the next tie grants port 0.
